bram_port_arbiter: RTL and testbench

- Shares the single-port frame BRAM (14-bit address, 8-bit data) between two requesters:
  - the capture writer (RX), which produces pixels from the HP display bus;
  - the VGA scan-out reader (TX).
- TX reads get absolute priority so scan-out never stalls.
- RX writes go into a small FIFO and drain into idle BRAM cycles (blanking and gaps).
- Sits between the RX/TX blocks and the BRAM primitive in the iCE40 top level.

---
 rtl/hp2vga_pkg.sv | 15 +
 rtl/bram_wr_fifo.sv | 62 ++++++
 rtl/bram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp2vga_pkg.sv
// Shared HP-bus to VGA frame-buffer definitions.
// Frame geometry, bus widths and the BRAM slot encoding.
package hp2vga_pkg;

  localparam int BRAM_ADDR_W = 14;
  localparam int PIX_DATA_W = 8;
  localparam int FRAME_PIXELS = 576 * 378;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

endpackage

// File: rtl/bram_wr_fifo.sv
// Capture-side write FIFO with show-ahead head.
// Holds {addr, data} words until the BRAM has a free slot.
module bram_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Full blocks the push even when a pop frees a slot this cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Frame BRAM port sharing: scan-out reads always win,
// capture writes queue and drain into idle slots.
module bram_port_arbiter
  import hp2vga_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = PIX_DATA_W,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX_WR_REQ,
  input  logic [ADDR_W-1:0] RX_WR_ADDR,
  input  logic [DATA_W-1:0] RX_WR_DATA,
  output logic              RX_WR_READY,
  input  logic              TX_RD_REQ,
  input  logic [ADDR_W-1:0] TX_RD_ADDR,
  output logic [DATA_W-1:0] TX_RD_DATA,
  output logic              TX_RD_VALID,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [DATA_W-1:0] BRAM_DIN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DOUT,
  input  logic              CLR_OVERFLOW,
  output logic              OVERFLOW,
  output logic [LVL_W-1:0]  FIFO_LEVEL
);

  localparam int ENT_W = ADDR_W + DATA_W;

  slot_e             r_slot;
  slot_e             w_slot_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] w_din_nxt;
  logic              r_we;
  logic              r_tag2;
  logic              r_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ovf;
  logic [ENT_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_push = RX_WR_REQ & ~w_full;
  assign w_pop  = ~TX_RD_REQ & ~w_empty;

  bram_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_din   ({RX_WR_ADDR, RX_WR_DATA}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  always_comb begin
    w_slot_nxt = SLOT_IDLE;
    w_addr_nxt = r_addr;
    w_din_nxt  = r_din;
    unique case (1'b1)
      TX_RD_REQ: begin
        w_slot_nxt = SLOT_READ;
        w_addr_nxt = TX_RD_ADDR;
      end
      w_pop: begin
        w_slot_nxt = SLOT_WRITE;
        w_addr_nxt = w_head[ENT_W-1 -: ADDR_W];
        w_din_nxt  = w_head[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_slot <= SLOT_IDLE;
      r_addr <= '0;
      r_din  <= '0;
      r_we   <= 1'b0;
    end else begin
      r_slot <= w_slot_nxt;
      r_addr <= w_addr_nxt;
      r_din  <= w_din_nxt;
      r_we   <= (w_slot_nxt == SLOT_WRITE);
    end
  end

  // A read slot is the first tag stage; BRAM data lands one edge later.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tag2    <= 1'b0;
      r_valid   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_tag2  <= (r_slot == SLOT_READ);
      r_valid <= r_tag2;
      if (r_tag2) begin
        r_rd_data <= BRAM_DOUT;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ovf <= 1'b0;
    end else if (RX_WR_REQ && w_full) begin
      r_ovf <= 1'b1;
    end else if (CLR_OVERFLOW) begin
      r_ovf <= 1'b0;
    end
  end

  assign RX_WR_READY = ~w_full;
  assign TX_RD_DATA  = r_rd_data;
  assign TX_RD_VALID = r_valid;
  assign BRAM_ADDR   = r_addr;
  assign BRAM_DIN    = r_din;
  assign BRAM_WE     = r_we;
  assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a BRAM model
// and a queue-level reference of the read/write slot rules.
module tb_bram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } wr_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          RX_WR_REQ = 1'b0;
  logic [AW-1:0] RX_WR_ADDR = '0;
  logic [DW-1:0] RX_WR_DATA = '0;
  logic          RX_WR_READY;
  logic          TX_RD_REQ = 1'b0;
  logic [AW-1:0] TX_RD_ADDR = '0;
  logic [DW-1:0] TX_RD_DATA;
  logic          TX_RD_VALID;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DIN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DOUT = '0;
  logic          CLR_OVERFLOW = 1'b0;
  logic          OVERFLOW;
  logic [4:0]    FIFO_LEVEL;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] bram_mem [int];
  logic [DW-1:0] ref_mem [int];
  wr_t ref_q [$];
  wr_t exp_wr [$];
  rd_t exp_rd [$];
  bit  ref_ovf = 1'b0;
  wr_t pend;
  bit  pend_v = 1'b0;
  wr_t w;
  rd_t r;
  bit  full;
  wr_t mw;
  rd_t mr;

  bram_port_arbiter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX_WR_REQ    (RX_WR_REQ),
    .RX_WR_ADDR   (RX_WR_ADDR),
    .RX_WR_DATA   (RX_WR_DATA),
    .RX_WR_READY  (RX_WR_READY),
    .TX_RD_REQ    (TX_RD_REQ),
    .TX_RD_ADDR   (TX_RD_ADDR),
    .TX_RD_DATA   (TX_RD_DATA),
    .TX_RD_VALID  (TX_RD_VALID),
    .BRAM_ADDR    (BRAM_ADDR),
    .BRAM_DIN     (BRAM_DIN),
    .BRAM_WE      (BRAM_WE),
    .BRAM_DOUT    (BRAM_DOUT),
    .CLR_OVERFLOW (CLR_OVERFLOW),
    .OVERFLOW     (OVERFLOW),
    .FIFO_LEVEL   (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    if (a == 14'h0123) return 8'h5A;
    if (a == 14'h0200) return 8'h11;
    return 8'(a * 7 + 3) ^ 8'(a >> 6);
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Synchronous single-port BRAM, read data one clock after address.
  always @(posedge CLK) begin
    if (bram_mem.exists(int'(BRAM_ADDR)))
      BRAM_DOUT <= bram_mem[int'(BRAM_ADDR)];
    else
      BRAM_DOUT <= init_val(BRAM_ADDR);
    if (BRAM_WE) bram_mem[int'(BRAM_ADDR)] = BRAM_DIN;
  end

  // Reference: reads take the slot, else the oldest queued write.
  // A granted write lands in memory on the following edge.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ref_q.delete();
      exp_rd.delete();
      exp_wr.delete();
      ref_ovf = 1'b0;
      pend_v = 1'b0;
    end else begin
      cyc++;
      if (pend_v) begin
        ref_mem[int'(pend.addr)] = pend.data;
        pend_v = 1'b0;
      end
      full = (ref_q.size() >= DEPTH);
      if (TX_RD_REQ) begin
        r.data = ref_rd(TX_RD_ADDR);
        r.due = cyc + 2;
        exp_rd.push_back(r);
      end else if (ref_q.size() > 0) begin
        w = ref_q.pop_front();
        w.due = cyc;
        exp_wr.push_back(w);
        pend = w;
        pend_v = 1'b1;
      end
      if (RX_WR_REQ && full) begin
        ref_ovf = 1'b1;
      end else begin
        if (RX_WR_REQ) begin
          w.addr = RX_WR_ADDR;
          w.data = RX_WR_DATA;
          w.due = 0;
          ref_q.push_back(w);
        end
        if (CLR_OVERFLOW) ref_ovf = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
        mr = exp_rd.pop_front();
        chk("rd_valid", 32'(TX_RD_VALID), 32'd1);
        chk("rd_data", 32'(TX_RD_DATA), 32'(mr.data));
      end else begin
        chk("rd_spurious", 32'(TX_RD_VALID), 32'd0);
      end
      if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
        mw = exp_wr.pop_front();
        chk("wr_we", 32'(BRAM_WE), 32'd1);
        chk("wr_addr", 32'(BRAM_ADDR), 32'(mw.addr));
        chk("wr_data", 32'(BRAM_DIN), 32'(mw.data));
      end else begin
        chk("wr_spurious", 32'(BRAM_WE), 32'd0);
      end
      chk("level", 32'(FIFO_LEVEL), 32'(ref_q.size()));
      chk("ready", 32'(RX_WR_READY), 32'(ref_q.size() < DEPTH));
      chk("overflow", 32'(OVERFLOW), 32'(ref_ovf));
    end
  end

  task automatic drive(bit rd, logic [AW-1:0] ra, bit wr,
                       logic [AW-1:0] wa, logic [DW-1:0] wd,
                       bit clr);
    TX_RD_REQ = rd;
    TX_RD_ADDR = ra;
    RX_WR_REQ = wr;
    RX_WR_ADDR = wa;
    RX_WR_DATA = wd;
    CLR_OVERFLOW = clr;
    @(negedge CLK);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    int mism;
    #1;
    chk("rst_addr", 32'(BRAM_ADDR), 32'd0);
    chk("rst_din", 32'(BRAM_DIN), 32'd0);
    chk("rst_we", 32'(BRAM_WE), 32'd0);
    chk("rst_rdata", 32'(TX_RD_DATA), 32'd0);
    chk("rst_valid", 32'(TX_RD_VALID), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_ready", 32'(RX_WR_READY), 32'd1);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // single read, two-clock latency
    drive(1, 14'h0123, 0, '0, '0, 0);
    chk("t1_addr", 32'(BRAM_ADDR), 32'h0123);
    chk("t1_we", 32'(BRAM_WE), 32'd0);
    idle(2);
    chk("t1_valid", 32'(TX_RD_VALID), 32'd1);
    chk("t1_data", 32'(TX_RD_DATA), 32'h5A);
    idle(3);

    // four writes drain into idle slots
    for (int i = 0; i < 4; i++)
      drive(0, '0, 1, 14'(16 + i), 8'(8'hA0 + i), 0);
    idle(3);
    chk("t2_level", 32'(FIFO_LEVEL), 32'd0);

    // reads starve writes
    for (int i = 0; i < 20; i++)
      drive(1, 14'(64 + i), bit'(i < 3), 14'(32 + i),
            8'(8'hB0 + i), 0);
    chk("t3_level", 32'(FIFO_LEVEL), 32'd3);
    idle(1);
    chk("t3_we", 32'(BRAM_WE), 32'd1);
    chk("t3_addr", 32'(BRAM_ADDR), 32'h0020);
    idle(4);
    chk("t3_drained", 32'(FIFO_LEVEL), 32'd0);

    // fill to full, then overflow
    for (int i = 0; i < 17; i++) begin
      drive(1, 14'h0050, 1, 14'(14'h0300 + i), 8'(i), 0);
      if (i == 15) chk("t4_ready", 32'(RX_WR_READY), 32'd0);
    end
    chk("t4_ovf_set", 32'(OVERFLOW), 32'd1);
    chk("t4_level", 32'(FIFO_LEVEL), 32'd16);
    drive(1, 14'h0050, 0, '0, '0, 1);
    chk("t4_ovf_clr", 32'(OVERFLOW), 32'd0);
    drive(1, 14'h0050, 1, 14'h0333, 8'h33, 1);
    chk("t4_set_wins", 32'(OVERFLOW), 32'd1);
    idle(20);
    chk("t4_drained", 32'(FIFO_LEVEL), 32'd0);
    drive(0, '0, 0, '0, '0, 1);
    idle(2);

    // asynchronous reset mid-drain
    for (int i = 0; i < 6; i++)
      drive(1, 14'h0060, 1, 14'(14'h0400 + i), 8'(8'hC0 + i), 0);
    idle(1);
    chk("t5_pre_we", 32'(BRAM_WE), 32'd1);
    chk("t5_pre_level", 32'(FIFO_LEVEL), 32'd5);
    #2 RESET = 1'b1;
    #1;
    chk("t5_we", 32'(BRAM_WE), 32'd0);
    chk("t5_level", 32'(FIFO_LEVEL), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    idle(6);

    // pending write is not forwarded to reads
    for (int i = 0; i < 8; i++) begin
      drive(1, 14'h0200, bit'(i == 0), 14'h0200, 8'h77, 0);
      if (i == 4) chk("t6_old", 32'(TX_RD_DATA), 32'h11);
    end
    idle(1);
    drive(1, 14'h0200, 0, '0, '0, 0);
    idle(2);
    chk("t6_new", 32'(TX_RD_DATA), 32'h77);
    idle(2);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++)
      drive(bit'($urandom_range(0, 99) < 55),
            14'($urandom_range(0, 31)),
            bit'($urandom_range(0, 99) < 50),
            14'($urandom_range(0, 31)),
            8'($urandom),
            bit'($urandom_range(0, 99) < 8));
    idle(30);

    chk("rd_pending", 32'(exp_rd.size()), 32'd0);
    chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    mism = 0;
    foreach (ref_mem[k])
      if (!bram_mem.exists(k) || bram_mem[k] !== ref_mem[k])
        mism++;
    foreach (bram_mem[k])
      if (!ref_mem.exists(k)) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
